xvga_timing_gen: RTL and testbench

- Parametrised successor to the fixed 1024x768 XVGA timing generator.
- Horizontal and vertical geometry, sync polarity and counter widths are all parameters, so one block covers 1024x768, 1280x1024 and small simulation modes.
- Adds a pixel-enable input, one-cycle line_start and frame_start strobes, and a built-in PIPE_DELAY-stage aligned delay line, so downstream pixel pipelines tap timing that is already matched to their latency.
- Sits at the root of the video path, driving the scope trace renderer and the VGA pins.

---
 rtl/xvga_pkg.sv | 40 ++++
 rtl/xvga_timing_pipe.sv | 33 +++
 rtl/xvga_timing_gen.sv | 118 +++++++++++
 tb/tb_xvga_timing_gen.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/xvga_pkg.sv
// Shared timing presets for the xvga timing generator family.
// Each preset gives active/front-porch/sync/back-porch for both axes plus sync polarity.
package xvga_pkg;

  localparam int  XVGA_1024x768_H_ACTIVE  = 1024;
  localparam int  XVGA_1024x768_H_FP      = 24;
  localparam int  XVGA_1024x768_H_SYNC    = 136;
  localparam int  XVGA_1024x768_H_BP      = 160;
  localparam int  XVGA_1024x768_V_ACTIVE  = 768;
  localparam int  XVGA_1024x768_V_FP      = 3;
  localparam int  XVGA_1024x768_V_SYNC    = 6;
  localparam int  XVGA_1024x768_V_BP      = 29;
  localparam logic XVGA_1024x768_POL      = 1'b0;

  localparam int  XVGA_1280x1024_H_ACTIVE = 1280;
  localparam int  XVGA_1280x1024_H_FP     = 48;
  localparam int  XVGA_1280x1024_H_SYNC   = 112;
  localparam int  XVGA_1280x1024_H_BP     = 248;
  localparam int  XVGA_1280x1024_V_ACTIVE = 1024;
  localparam int  XVGA_1280x1024_V_FP     = 1;
  localparam int  XVGA_1280x1024_V_SYNC   = 3;
  localparam int  XVGA_1280x1024_V_BP     = 38;
  localparam logic XVGA_1280x1024_POL     = 1'b1;

  // Small mode for fast simulation: 16 pixels per line, 8 lines per frame.
  localparam int  SIM_TINY_H_ACTIVE       = 8;
  localparam int  SIM_TINY_H_FP           = 2;
  localparam int  SIM_TINY_H_SYNC         = 3;
  localparam int  SIM_TINY_H_BP           = 3;
  localparam int  SIM_TINY_V_ACTIVE       = 4;
  localparam int  SIM_TINY_V_FP           = 1;
  localparam int  SIM_TINY_V_SYNC         = 2;
  localparam int  SIM_TINY_V_BP           = 1;
  localparam logic SIM_TINY_POL           = 1'b0;

  function automatic int timing_total(int active, int fp, int sync, int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/xvga_timing_pipe.sv
// N-stage register delay for the packed timing bundle; every stage clocks
// each vclock and loads RST_VAL on synchronous reset.
module xvga_timing_pipe #(
  parameter int            W       = 1,
  parameter int            N       = 0,
  parameter logic [W-1:0]  RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  if (N == 0) begin : g_bypass
    logic unused_ctrl;
    assign unused_ctrl = &{1'b0, clk, rst_n};
    assign q = d;
  end else begin : g_stages
    logic [W-1:0] stg_q [N];

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int i = 0; i < N; i++) stg_q[i] <= RST_VAL;
      end else begin
        stg_q[0] <= d;
        for (int i = 1; i < N; i++) stg_q[i] <= stg_q[i-1];
      end
    end

    assign q = stg_q[N-1];
  end

endmodule

// File: rtl/xvga_timing_gen.sv
// Parametrised video timing generator: pixel/line counters with enable,
// registered sync/blank/strobe outputs and an aligned PIPE_DELAY delay line.
module xvga_timing_gen
  import xvga_pkg::*;
#(
  parameter int   H_ACTIVE   = 1024,
  parameter int   H_FP       = 24,
  parameter int   H_SYNC     = 136,
  parameter int   H_BP       = 160,
  parameter int   V_ACTIVE   = 768,
  parameter int   V_FP       = 3,
  parameter int   V_SYNC     = 6,
  parameter int   V_BP       = 29,
  parameter logic H_POL      = 1'b0,
  parameter logic V_POL      = 1'b0,
  parameter int   X_W        = 12,
  parameter int   Y_W        = 12,
  parameter int   PIPE_DELAY = 0
) (
  input  logic           vclock,
  input  logic           rst_n,
  input  logic           en,
  output logic [X_W-1:0] displayX,
  output logic [Y_W-1:0] displayY,
  output logic           hsync,
  output logic           vsync,
  output logic           blank,
  output logic           line_start,
  output logic           frame_start
);

  localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int BUS_W   = X_W + Y_W + 5;

  if (H_BP < 1 || V_BP < 1 || H_SYNC < 1 || V_SYNC < 1 ||
      longint'(H_TOTAL) > (longint'(1) << X_W) ||
      longint'(V_TOTAL) > (longint'(1) << Y_W) ||
      PIPE_DELAY < 0 || PIPE_DELAY > 16) begin : g_bad_cfg
    $fatal(1, "xvga_timing_gen: illegal timing parameters");
  end

  // Back porch >= 1 keeps every boundary below TOTAL, so all fit in the counter width.
  localparam logic [X_W-1:0] X_MAX    = X_W'(H_TOTAL - 1);
  localparam logic [Y_W-1:0] Y_MAX    = Y_W'(V_TOTAL - 1);
  localparam logic [X_W-1:0] X_VIS    = X_W'(H_ACTIVE);
  localparam logic [Y_W-1:0] Y_VIS    = Y_W'(V_ACTIVE);
  localparam logic [X_W-1:0] HS_BEG   = X_W'(H_ACTIVE + H_FP);
  localparam logic [X_W-1:0] HS_END   = X_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [Y_W-1:0] VS_BEG   = Y_W'(V_ACTIVE + V_FP);
  localparam logic [Y_W-1:0] VS_END   = Y_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [BUS_W-1:0] RST_BUS = {X_MAX, Y_MAX, ~H_POL, ~V_POL, 1'b1, 1'b0, 1'b0};

  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic           hs_d, vs_d, bl_d, ls_d, fs_d;
  logic [X_W-1:0] s0_x_q;
  logic [Y_W-1:0] s0_y_q;
  logic           s0_hs_q, s0_vs_q, s0_bl_q, s0_ls_q, s0_fs_q;
  logic [BUS_W-1:0] pipe_out;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (en) begin
      if (x_q == X_MAX) begin
        x_d = '0;
        y_d = (y_q == Y_MAX) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
    hs_d = ((x_d >= HS_BEG) && (x_d < HS_END)) ? H_POL : ~H_POL;
    vs_d = ((y_d >= VS_BEG) && (y_d < VS_END)) ? V_POL : ~V_POL;
    bl_d = (x_d >= X_VIS) || (y_d >= Y_VIS);
    ls_d = en && (x_d == '0);
    fs_d = ls_d && (y_d == '0);
  end

  // Stage 0 is derived from the next-counter values so all outputs describe one pixel.
  always_ff @(posedge vclock) begin
    if (!rst_n) begin
      x_q     <= X_MAX;
      y_q     <= Y_MAX;
      s0_x_q  <= X_MAX;
      s0_y_q  <= Y_MAX;
      s0_hs_q <= ~H_POL;
      s0_vs_q <= ~V_POL;
      s0_bl_q <= 1'b1;
      s0_ls_q <= 1'b0;
      s0_fs_q <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      s0_x_q  <= x_d;
      s0_y_q  <= y_d;
      s0_hs_q <= hs_d;
      s0_vs_q <= vs_d;
      s0_bl_q <= bl_d;
      s0_ls_q <= ls_d;
      s0_fs_q <= fs_d;
    end
  end

  xvga_timing_pipe #(
    .W       (BUS_W),
    .N       (PIPE_DELAY),
    .RST_VAL (RST_BUS)
  ) u_pipe (
    .clk   (vclock),
    .rst_n (rst_n),
    .d     ({s0_x_q, s0_y_q, s0_hs_q, s0_vs_q, s0_bl_q, s0_ls_q, s0_fs_q}),
    .q     (pipe_out)
  );

  assign {displayX, displayY, hsync, vsync, blank, line_start, frame_start} = pipe_out;

endmodule

// File: tb/tb_xvga_timing_gen.sv
// Bench for xvga_timing_gen: two SIM_TINY instances (delay 0 and 3) checked against a
// linear pixel-index reference model, plus a default 1024x768 instance checked per line.
module tb_xvga_timing_gen;
  import xvga_pkg::*;

  localparam int TH = 16, TV = 8, TF = TH * TV;
  localparam logic [11:0] RST = {4'd15, 3'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

  logic vclock = 1'b0;
  logic rst_n  = 1'b0;
  logic en     = 1'b0;

  logic [3:0]  d0_x, d3_x;
  logic [2:0]  d0_y, d3_y;
  logic        d0_hs, d0_vs, d0_bl, d0_ls, d0_fs;
  logic        d3_hs, d3_vs, d3_bl, d3_ls, d3_fs;
  logic [11:0] b_x, b_y;
  logic        b_hs, b_vs, b_bl, b_ls, b_fs;

  wire [11:0] act0 = {d0_x, d0_y, d0_hs, d0_vs, d0_bl, d0_ls, d0_fs};
  wire [11:0] act3 = {d3_x, d3_y, d3_hs, d3_vs, d3_bl, d3_ls, d3_fs};

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: linear pixel index within the frame plus an expected-output history.
  int          p;
  logic [11:0] hist [4];

  always #5 vclock = ~vclock;

  xvga_timing_gen #(
    .H_ACTIVE(SIM_TINY_H_ACTIVE), .H_FP(SIM_TINY_H_FP), .H_SYNC(SIM_TINY_H_SYNC), .H_BP(SIM_TINY_H_BP),
    .V_ACTIVE(SIM_TINY_V_ACTIVE), .V_FP(SIM_TINY_V_FP), .V_SYNC(SIM_TINY_V_SYNC), .V_BP(SIM_TINY_V_BP),
    .H_POL(SIM_TINY_POL), .V_POL(SIM_TINY_POL), .X_W(4), .Y_W(3), .PIPE_DELAY(0)
  ) dut0 (
    .vclock(vclock), .rst_n(rst_n), .en(en), .displayX(d0_x), .displayY(d0_y),
    .hsync(d0_hs), .vsync(d0_vs), .blank(d0_bl), .line_start(d0_ls), .frame_start(d0_fs)
  );

  xvga_timing_gen #(
    .H_ACTIVE(SIM_TINY_H_ACTIVE), .H_FP(SIM_TINY_H_FP), .H_SYNC(SIM_TINY_H_SYNC), .H_BP(SIM_TINY_H_BP),
    .V_ACTIVE(SIM_TINY_V_ACTIVE), .V_FP(SIM_TINY_V_FP), .V_SYNC(SIM_TINY_V_SYNC), .V_BP(SIM_TINY_V_BP),
    .H_POL(SIM_TINY_POL), .V_POL(SIM_TINY_POL), .X_W(4), .Y_W(3), .PIPE_DELAY(3)
  ) dut3 (
    .vclock(vclock), .rst_n(rst_n), .en(en), .displayX(d3_x), .displayY(d3_y),
    .hsync(d3_hs), .vsync(d3_vs), .blank(d3_bl), .line_start(d3_ls), .frame_start(d3_fs)
  );

  xvga_timing_gen dut_big (
    .vclock(vclock), .rst_n(rst_n), .en(1'b1), .displayX(b_x), .displayY(b_y),
    .hsync(b_hs), .vsync(b_vs), .blank(b_bl), .line_start(b_ls), .frame_start(b_fs)
  );

  function automatic logic [11:0] expect_out(int pp, bit adv);
    int x, y;
    x = pp % TH;
    y = pp / TH;
    return {4'(x), 3'(y), !(x >= 10 && x < 13), !(y >= 5 && y < 7),
            (x >= 8 || y >= 4), (adv && x == 0), (adv && pp == 0)};
  endfunction

  task automatic tick();
    @(posedge vclock);
    if (!rst_n) begin
      p = TF - 1;
      for (int i = 0; i < 4; i++) hist[i] = RST;
    end else begin
      for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
      if (en) p = (p + 1) % TF;
      hist[0] = expect_out(p, en);
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en    = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_cmp++;
      if (act0 !== RST) begin n_err++; $display("FAIL reset_d0: got %h want %h", act0, RST); end
      n_cmp++;
      if (act3 !== RST) begin n_err++; $display("FAIL reset_d3: got %h want %h", act3, RST); end
    end
  endtask

  task automatic test_first_frame();
    int last_ls, last_fs;
    logic prev_vs;
    last_ls = -1;
    last_fs = -1;
    prev_vs = d0_vs;
    rst_n = 1'b1;
    en    = 1'b1;
    for (int c = 0; c < 2 * TF + 5; c++) begin
      tick();
      if (c == 0) begin
        n_cmp++;
        if ({d0_x, d0_y, d0_bl, d0_fs} !== {4'd0, 3'd0, 1'b0, 1'b1}) begin
          n_err++;
          $display("FAIL first_pixel: got x=%0d y=%0d bl=%b fs=%b want 0 0 0 1", d0_x, d0_y, d0_bl, d0_fs);
        end
      end
      n_cmp++;
      if (act0 !== hist[0]) begin n_err++; $display("FAIL frame_d0 cyc %0d: got %h want %h", c, act0, hist[0]); end
      n_cmp++;
      if (act3 !== hist[3]) begin n_err++; $display("FAIL frame_d3 cyc %0d: got %h want %h", c, act3, hist[3]); end
      if (d0_ls) begin
        if (last_ls >= 0) begin
          n_cmp++;
          if (c - last_ls !== TH) begin n_err++; $display("FAIL line_period: got %0d want %0d", c - last_ls, TH); end
        end
        last_ls = c;
      end
      if (d0_fs) begin
        if (last_fs >= 0) begin
          n_cmp++;
          if (c - last_fs !== TF) begin n_err++; $display("FAIL frame_period: got %0d want %0d", c - last_fs, TF); end
        end
        last_fs = c;
      end
      if (d0_vs !== prev_vs) begin
        n_cmp++;
        if (d0_x !== 4'd0) begin n_err++; $display("FAIL vsync_edge: changed at x=%0d want x=0", d0_x); end
      end
      prev_vs = d0_vs;
    end
  endtask

  task automatic test_en_toggle();
    int hs_run, ls_run;
    hs_run = -1;
    ls_run = 0;
    for (int c = 0; c < 200; c++) begin
      en = (c % 2 == 0);
      tick();
      n_cmp++;
      if (act0 !== hist[0]) begin n_err++; $display("FAIL en_toggle_d0 cyc %0d: got %h want %h", c, act0, hist[0]); end
      n_cmp++;
      if (act3 !== hist[3]) begin n_err++; $display("FAIL en_toggle_d3 cyc %0d: got %h want %h", c, act3, hist[3]); end
      if (d0_hs == 1'b0) begin
        if (hs_run >= 0) hs_run++;
      end else begin
        if (hs_run > 0) begin
          n_cmp++;
          if (hs_run !== 6) begin n_err++; $display("FAIL hsync_width_halfrate: got %0d want 6", hs_run); end
        end
        hs_run = 0;
      end
      if (d0_ls) ls_run++;
      else begin
        if (ls_run > 0) begin
          n_cmp++;
          if (ls_run !== 1) begin n_err++; $display("FAIL line_start_width: got %0d want 1", ls_run); end
        end
        ls_run = 0;
      end
    end
  endtask

  task automatic test_random_en();
    for (int c = 0; c < 500; c++) begin
      en = 1'($urandom_range(0, 1));
      tick();
      n_cmp++;
      if (act0 !== hist[0]) begin n_err++; $display("FAIL rand_d0 cyc %0d: got %h want %h", c, act0, hist[0]); end
      n_cmp++;
      if (act3 !== hist[3]) begin n_err++; $display("FAIL rand_d3 cyc %0d: got %h want %h", c, act3, hist[3]); end
    end
  endtask

  task automatic test_big_line();
    int bc, last_ls, hs_run, vis_cnt, line_y;
    logic [11:0] prev_x;
    last_ls = -1;
    hs_run  = -1;
    vis_cnt = -1;
    line_y  = 0;
    prev_x  = b_x;
    en = 1'b1;
    for (bc = 0; bc < 3 * 1344 + 300; bc++) begin
      tick();
      n_cmp++;
      if (b_x !== 12'((int'(prev_x) + 1) % 1344)) begin
        n_err++; $display("FAIL big_x_step: got %0d want %0d", b_x, (int'(prev_x) + 1) % 1344);
      end
      prev_x = b_x;
      n_cmp++;
      if (b_fs !== (b_ls && b_y == 12'd0)) begin n_err++; $display("FAIL big_frame_start: got %b at y=%0d", b_fs, b_y); end
      if (b_ls) begin
        if (last_ls >= 0) begin
          n_cmp++;
          if (bc - last_ls !== 1344) begin n_err++; $display("FAIL big_line_period: got %0d want 1344", bc - last_ls); end
        end
        if (vis_cnt >= 0 && line_y < 768) begin
          n_cmp++;
          if (vis_cnt !== 1024) begin n_err++; $display("FAIL big_visible_width: got %0d want 1024", vis_cnt); end
        end
        last_ls = bc;
        vis_cnt = 0;
        line_y  = int'(b_y);
      end
      if (vis_cnt >= 0 && !b_bl) vis_cnt++;
      if (b_hs == 1'b0) begin
        if (hs_run >= 0) hs_run++;
      end else begin
        if (hs_run > 0) begin
          n_cmp++;
          if (hs_run !== 136) begin n_err++; $display("FAIL big_hsync_width: got %0d want 136", hs_run); end
        end
        hs_run = 0;
      end
    end
  endtask

  task automatic test_mid_reset();
    int guard;
    localparam logic [11:0] FIRST = {4'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    en = 1'b1;
    guard = 0;
    while (p != 2 * TH + 5 && guard < 300) begin
      tick();
      guard++;
    end
    n_cmp++;
    if (p != 2 * TH + 5) begin n_err++; $display("FAIL mid_reset_reach: got p=%0d want %0d", p, 2 * TH + 5); end
    n_cmp++;
    if ({d0_x, d0_y} !== {4'd5, 3'd2}) begin n_err++; $display("FAIL mid_reset_pos: got x=%0d y=%0d want 5 2", d0_x, d0_y); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_cmp++;
    if (act0 !== RST) begin n_err++; $display("FAIL mid_reset_d0: got %h want %h", act0, RST); end
    n_cmp++;
    if (act3 !== RST) begin n_err++; $display("FAIL mid_reset_d3: got %h want %h", act3, RST); end
    tick();
    n_cmp++;
    if (act0 !== FIRST) begin n_err++; $display("FAIL after_reset_d0: got %h want %h", act0, FIRST); end
    for (int c = 0; c < 3; c++) begin
      n_cmp++;
      if (act3 !== RST) begin n_err++; $display("FAIL after_reset_d3_hold %0d: got %h want %h", c, act3, RST); end
      tick();
    end
    n_cmp++;
    if (act3 !== FIRST) begin n_err++; $display("FAIL after_reset_d3: got %h want %h", act3, FIRST); end
    n_cmp++;
    if (act0 !== hist[0]) begin n_err++; $display("FAIL after_reset_model_d0: got %h want %h", act0, hist[0]); end
  endtask

  initial begin
    p = TF - 1;
    for (int i = 0; i < 4; i++) hist[i] = RST;
    test_reset();
    test_first_frame();
    test_en_toggle();
    test_random_en();
    test_big_line();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
